// File: rtl/featuremap_channel_accum.sv
// Purpose : sums NUM_CH per-channel conv results plus bias into one saturated output pixel; counts pixels per frame.
// Latency : 1 cycle from the cycle in which the last missing channel is valid to valid_out.
// Backpr. : none; one pixel per cycle sustained, the downstream must take every valid_out pulse.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   ch_data_in    NUM_CH packed signed samples, channel i on [i*DATA_WIDTH +: DATA_WIDTH]
//   ch_valid_in   per-channel 1-cycle result strobe
//   bias          signed bias, sampled in the fire cycle
//   data_out      saturated sum, holds between pulses
//   valid_out     1-cycle pulse per output pixel
//   frame_done    pulses with valid_out of the last pixel of a frame
//   overrun       sticky: a channel delivered twice within one pixel
module featuremap_channel_accum #(
    parameter int DATA_WIDTH = 24,
    parameter int NUM_CH     = 6,
    parameter int OUT_H      = 10,
    parameter int OUT_W      = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data_in,
    input  logic [NUM_CH-1:0]            ch_valid_in,
    input  logic [DATA_WIDTH-1:0]        bias,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         valid_out,
    output logic                         frame_done,
    output logic                         overrun
);

    // Enough headroom that NUM_CH samples plus the bias never wrap.
    localparam int SUM_W = DATA_WIDTH + $clog2(NUM_CH + 1);
    localparam int EXT_W = SUM_W - DATA_WIDTH;
    localparam int NPIX  = OUT_H * OUT_W;
    localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;

    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(EXT_W + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(EXT_W + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    logic [DATA_WIDTH-1:0]   r_hold [NUM_CH];
    logic [NUM_CH-1:0]       r_hold_full;
    logic [CNT_W-1:0]        r_pix_cnt;

    logic                    w_fire;
    logic [DATA_WIDTH-1:0]   w_eff [NUM_CH];
    logic signed [SUM_W-1:0] w_sum;
    logic [DATA_WIDTH-1:0]   w_sat;

    // Fire once every channel is either already held or arriving this cycle.
    assign w_fire = &(r_hold_full | ch_valid_in);

    // A held sample always wins over a same-cycle duplicate (the duplicate is an overrun).
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_eff[i] = r_hold_full[i] ? r_hold[i]
                                      : ch_data_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        w_sum = {{EXT_W{bias[DATA_WIDTH-1]}}, bias};
        for (int i = 0; i < NUM_CH; i++) begin
            w_sum = w_sum + {{EXT_W{w_eff[i][DATA_WIDTH-1]}}, w_eff[i]};
        end
    end

    always_comb begin
        w_sat = w_sum[DATA_WIDTH-1:0];
        if (w_sum > SAT_MAX) begin
            w_sat = SAT_MAX[DATA_WIDTH-1:0];
        end else if (w_sum < SAT_MIN) begin
            w_sat = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_full <= '0;
            r_pix_cnt   <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            valid_out  <= w_fire;
            frame_done <= w_fire && (r_pix_cnt == LAST_PIX);

            if (|(ch_valid_in & r_hold_full)) begin
                overrun <= 1'b1;
            end

            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_valid_in[i] && !r_hold_full[i]) begin
                    r_hold[i] <= ch_data_in[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end

            if (w_fire) begin
                r_hold_full <= '0;
                data_out    <= w_sat;
                r_pix_cnt   <= (r_pix_cnt == LAST_PIX) ? '0 : r_pix_cnt + 1'b1;
            end else begin
                r_hold_full <= r_hold_full | ch_valid_in;
            end
        end
    end

endmodule

// File: tb/tb_featuremap_channel_accum.sv
module tb_featuremap_channel_accum;

    localparam int DW = 24;
    localparam int NC = 6;

    logic               clk;
    logic               rst;
    logic [NC*DW-1:0]   ch_data_in;
    logic [NC-1:0]      ch_valid_in;
    logic [DW-1:0]      bias;
    logic [DW-1:0]      data_out;
    logic               valid_out;
    logic               frame_done;
    logic               overrun;

    int n_tests = 0;
    int n_fail  = 0;

    featuremap_channel_accum #(
        .DATA_WIDTH(DW), .NUM_CH(NC), .OUT_H(10), .OUT_W(10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ch_data_in (ch_data_in),
        .ch_valid_in(ch_valid_in),
        .bias       (bias),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ch_valid_in = '0;
        ch_data_in  = '0;
        bias        = '0;
    endtask

    task automatic drive(input logic [NC-1:0] mask, input logic [DW-1:0] val);
        ch_valid_in = mask;
        for (int i = 0; i < NC; i++) ch_data_in[i*DW +: DW] = val;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({data_out, valid_out, frame_done, overrun} !== {24'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_state: got d=%h v=%b fd=%b ov=%b, want all 0",
                     data_out, valid_out, frame_done, overrun);
        end
    endtask

    // T1: all channels at once, data 1..6, bias 10.
    task automatic test_all_at_once();
        ch_valid_in = '1;
        for (int i = 0; i < NC; i++) ch_data_in[i*DW +: DW] = DW'(i + 1);
        bias = 24'd10;
        tick();
        idle();
        n_tests++;
        if (valid_out !== 1'b1 || data_out !== 24'd31) begin
            n_fail++;
            $display("FAIL t1_fire: got v=%b d=%0d, want v=1 d=31", valid_out, data_out);
        end
        tick();
        n_tests++;
        if (valid_out !== 1'b0 || data_out !== 24'd31) begin
            n_fail++;
            $display("FAIL t1_pulse_end: got v=%b d=%0d, want v=0 d=31", valid_out, data_out);
        end
    endtask

    // T2: channels trickle in one per cycle.
    task automatic test_staggered();
        for (int c = 0; c < NC; c++) begin
            drive(NC'(1) << c, 24'd100);
            tick();
            n_tests++;
            if (c < NC - 1) begin
                if (valid_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL t2_early_pulse: ch%0d got v=%b, want v=0", c, valid_out);
                end
            end else if (valid_out !== 1'b1 || data_out !== 24'd600) begin
                n_fail++;
                $display("FAIL t2_fire: got v=%b d=%0d, want v=1 d=600", valid_out, data_out);
            end
        end
        idle();
        tick();
        n_tests++;
        if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL t2_pulse_end: got v=%b, want v=0", valid_out);
        end
    endtask

    // T3: positive and negative saturation.
    task automatic test_saturation();
        drive('1, 24'h7FFFFF);
        tick();
        n_tests++;
        if (valid_out !== 1'b1 || data_out !== 24'h7FFFFF) begin
            n_fail++;
            $display("FAIL t3_sat_max: got v=%b d=%h, want v=1 d=7fffff", valid_out, data_out);
        end
        drive('1, 24'h800000);
        tick();
        n_tests++;
        if (valid_out !== 1'b1 || data_out !== 24'h800000) begin
            n_fail++;
            $display("FAIL t3_sat_min: got v=%b d=%h, want v=1 d=800000", valid_out, data_out);
        end
        // Mixed signs within range: 4*(-3) + 2*5 + bias(-1) = -3.
        ch_valid_in = '1;
        for (int i = 0; i < NC; i++) ch_data_in[i*DW +: DW] = (i < 4) ? -24'sd3 : 24'sd5;
        bias = -24'sd1;
        tick();
        idle();
        n_tests++;
        if (valid_out !== 1'b1 || data_out !== 24'hFFFFFD) begin
            n_fail++;
            $display("FAIL t3_signed_sum: got v=%b d=%h, want v=1 d=fffffd", valid_out, data_out);
        end
        tick();
        n_tests++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_no_overrun: got ov=%b, want 0", overrun);
        end
    endtask

    // T4: ch2 delivered twice; the first value must be kept.
    task automatic test_overrun();
        drive(6'b000100, 24'd5);
        tick();
        drive(6'b000100, 24'd9);
        tick();
        n_tests++;
        if (overrun !== 1'b1 || valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL t4_overrun_set: got ov=%b v=%b, want ov=1 v=0", overrun, valid_out);
        end
        drive(6'b111011, 24'd1);
        tick();
        idle();
        n_tests++;
        if (valid_out !== 1'b1 || data_out !== 24'd10 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL t4_first_kept: got v=%b d=%0d ov=%b, want v=1 d=10 ov=1",
                     valid_out, data_out, overrun);
        end
        tick();
        n_tests++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL t4_sticky: got ov=%b, want 1", overrun);
        end
    endtask

    // T5: 101 back-to-back full sets from a fresh counter.
    task automatic test_back_to_back();
        do_reset();
        n_tests++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_reset_clears_overrun: got ov=%b, want 0", overrun);
        end
        for (int k = 1; k <= 101; k++) begin
            drive('1, 24'd1);
            tick();
            n_tests++;
            if ({valid_out, data_out, frame_done} !== {1'b1, 24'd6, (k == 100)}) begin
                n_fail++;
                $display("FAIL t5_set%0d: got v=%b d=%0d fd=%b, want v=1 d=6 fd=%b",
                         k, valid_out, data_out, frame_done, (k == 100));
            end
        end
        idle();
        tick();
        n_tests++;
        if (valid_out !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_idle: got v=%b fd=%b, want 0 0", valid_out, frame_done);
        end
    endtask

    // T6: reset mid-collection discards held channels, clears overrun and pixel count.
    task automatic test_reset_mid();
        drive(6'b000001, 24'd7);
        tick();
        drive(6'b000111, 24'd7);
        tick();
        n_tests++;
        if (overrun !== 1'b1 || valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_pre_reset: got ov=%b v=%b, want ov=1 v=0", overrun, valid_out);
        end
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if ({data_out, valid_out, overrun} !== {24'd0, 2'b00}) begin
            n_fail++;
            $display("FAIL t6_reset_state: got d=%0d v=%b ov=%b, want 0 0 0",
                     data_out, valid_out, overrun);
        end
        drive('1, 24'd2);
        tick();
        n_tests++;
        if ({valid_out, data_out, overrun, frame_done} !== {1'b1, 24'd12, 2'b00}) begin
            n_fail++;
            $display("FAIL t6_fire: got v=%b d=%0d ov=%b fd=%b, want v=1 d=12 ov=0 fd=0",
                     valid_out, data_out, overrun, frame_done);
        end
        // Pixel count restarted: frame_done must land on the 100th fire after reset.
        for (int k = 2; k <= 100; k++) begin
            drive('1, 24'd2);
            tick();
            n_tests++;
            if (frame_done !== (k == 100)) begin
                n_fail++;
                $display("FAIL t6_pix%0d: got fd=%b, want fd=%b", k, frame_done, (k == 100));
            end
        end
        idle();
        tick();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_all_at_once();
        test_staggered();
        test_saturation();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
